// File: rtl/mix_columns_ctrl.sv
// AES MixColumns / InvMixColumns over one 128-bit state, one 32-bit column per clock.
// Columns are transformed in place in a working register that also drives data_out.
module mix_columns_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         inv,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       r_state;
  logic [1:0]   r_col;
  logic         r_inv;
  logic         r_busy;
  logic         r_done;
  logic [127:0] r_data;
  logic [31:0]  w_col_in;
  logic [31:0]  w_col_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3,
            xtime(a1 ^ a2) ^ a2 ^ a3 ^ a0,
            xtime(a2 ^ a3) ^ a3 ^ a0 ^ a1,
            xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2};
  endfunction

  // Inverse = pre-conditioning with 4*(a0^a2) / 4*(a1^a3), then the forward matrix.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic do_inv);
    logic [7:0] u, v;
    logic [31:0] p;
    u = xtime(xtime(c[31:24] ^ c[15:8]));
    v = xtime(xtime(c[23:16] ^ c[7:0]));
    p = do_inv ? (c ^ {u, v, u, v}) : c;
    return mix_fwd(p);
  endfunction

  always_comb begin
    w_col_in = r_data[127:96];
    case (r_col)
      2'd0: w_col_in = r_data[127:96];
      2'd1: w_col_in = r_data[95:64];
      2'd2: w_col_in = r_data[63:32];
      2'd3: w_col_in = r_data[31:0];
      default: w_col_in = r_data[127:96];
    endcase
  end

  always_comb w_col_out = mix_col(w_col_in, r_inv);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_col   <= 2'd0;
      r_inv   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= 128'h0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_data  <= data_in;
            r_inv   <= inv;
            r_col   <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          case (r_col)
            2'd0: r_data[127:96] <= w_col_out;
            2'd1: r_data[95:64]  <= w_col_out;
            2'd2: r_data[63:32]  <= w_col_out;
            2'd3: r_data[31:0]   <= w_col_out;
            default: r_data[127:96] <= w_col_out;
          endcase
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_data;

endmodule

// File: tb/tb_mix_columns_ctrl.sv
// Bench for mix_columns_ctrl: directed vectors plus random operations against a GF(2^8) matrix model.
module tb_mix_columns_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         inv = 1'b0;
  logic [127:0] data_in = 128'h0;
  logic         busy;
  logic         done;
  logic [127:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  mix_columns_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv),
    .data_in(data_in), .busy(busy), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Matrix product on the first ncols columns; remaining columns pass through.
  function automatic logic [127:0] model(input logic [127:0] s, input logic minv, input int ncols);
    logic [7:0]   m[4];
    logic [7:0]   b;
    logic [127:0] r;
    if (minv) m = '{8'd14, 8'd11, 8'd13, 8'd9};
    else      m = '{8'd2, 8'd3, 8'd1, 8'd1};
    r = s;
    for (int c = 0; c < ncols; c++) begin
      for (int i = 0; i < 4; i++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++)
          b = b ^ gmul(m[(j - i + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
        r[127 - 8*(4*c + i) -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] din, exp_res, held;
  logic         m_inv;
  logic         saw_done;

  initial begin
    // reset state
    step();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_data", data_out, 0);
    rst = 1'b0;
    step();

    // forward known vector, column-by-column
    din = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    data_in = din; inv = 1'b0; start = 1'b1;
    step();
    start = 1'b0; data_in = rnd128();
    chk("fwd_e0_busy", busy, 1);
    chk("fwd_e0_data", data_out, din);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("fwd_e%0d_data", k), data_out, model(din, 1'b0, k));
      chk($sformatf("fwd_e%0d_busy", k), busy, (k < 4) ? 1 : 0);
      chk($sformatf("fwd_e%0d_done", k), done, (k == 4) ? 1 : 0);
    end
    chk("fwd_known", data_out, 128'h046681e5e0cb199a48f8d37a2806264c);
    step();
    chk("fwd_e5_done", done, 0);
    chk("fwd_hold", data_out, 128'h046681e5e0cb199a48f8d37a2806264c);

    // inverse known vector
    data_in = 128'h046681e5e0cb199a48f8d37a2806264c; inv = 1'b1; start = 1'b1;
    step();
    start = 1'b0; inv = 1'b0;
    repeat (4) step();
    chk("inv_done", done, 1);
    chk("inv_known", data_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    step();

    // per-column constant vectors, each column changes at its own edge
    data_in = 128'hdb135345_f20a225c_c6c6c6c6_d4bf5d30; inv = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("col_e1", data_out, 128'h8e4da1bc_f20a225c_c6c6c6c6_d4bf5d30);
    step();
    chk("col_e2", data_out, 128'h8e4da1bc_9fdc589d_c6c6c6c6_d4bf5d30);
    step();
    chk("col_e3", data_out, 128'h8e4da1bc_9fdc589d_c6c6c6c6_d4bf5d30);
    step();
    chk("col_e4", data_out, 128'h8e4da1bc_9fdc589d_c6c6c6c6_046681e5);
    step();

    // random single operations in both modes
    for (int n = 0; n < 12; n++) begin
      din = rnd128(); m_inv = 1'($urandom_range(0, 1));
      data_in = din; inv = m_inv; start = 1'b1;
      step();
      start = 1'b0; data_in = rnd128(); inv = ~m_inv;
      repeat (4) step();
      exp_res = model(din, m_inv, 4);
      chk($sformatf("rnd%0d_done", n), done, 1);
      chk($sformatf("rnd%0d_data", n), data_out, exp_res);
      step();
      chk($sformatf("rnd%0d_idle", n), {busy, done}, 0);
      chk($sformatf("rnd%0d_hold", n), data_out, exp_res);
    end

    // start held high: only E0 and done-cycle inputs are taken
    start = 1'b1;
    din = rnd128(); m_inv = 1'($urandom_range(0, 1));
    data_in = din; inv = m_inv;
    for (int op = 0; op < 3; op++) begin
      step();
      chk($sformatf("cont%0d_busy", op), busy, 1);
      for (int k = 1; k <= 4; k++) begin
        data_in = rnd128(); inv = 1'($urandom_range(0, 1));
        step();
      end
      chk($sformatf("cont%0d_done", op), done, 1);
      chk($sformatf("cont%0d_data", op), data_out, model(din, m_inv, 4));
      din = rnd128(); m_inv = 1'($urandom_range(0, 1));
      data_in = din; inv = m_inv;
    end
    start = 1'b0;
    step();
    step();
    chk("cont_idle", {busy, done}, 0);

    // reset after E2 aborts without done
    din = rnd128();
    data_in = din; inv = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_data", data_out, 0);
    saw_done = 1'b0;
    repeat (5) begin
      step();
      saw_done = saw_done | done;
    end
    chk("abort_no_done", saw_done, 0);
    din = rnd128(); m_inv = 1'b1;
    data_in = din; inv = m_inv; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("after_abort_done", done, 1);
    chk("after_abort_data", data_out, model(din, m_inv, 4));
    held = data_out;
    step();

    // start and rst together resolve to reset
    rst = 1'b1; start = 1'b1; data_in = rnd128();
    step();
    chk("rst_start_busy", busy, 0);
    chk("rst_start_done", done, 0);
    chk("rst_start_data", data_out, 0);
    step();
    chk("rst_start_hold", {busy, done, data_out}, 0);
    rst = 1'b0; start = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
